// File: rtl/gnr_attractor_ctrl.sv
// gnr_attractor_ctrl
//   Drives a GRN node array through a Floyd cycle search and then measures
//   the attractor period. The tortoise (s0) advances at half rate inside the
//   nodes, and the hare (s1) advances at full rate. After a meet, only the hare
//   is stepped until it returns to the frozen tortoise state.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   start         run request, honoured only while idle
//   init_vec      initial network state, captured when start is accepted
//   s0_vec        tortoise state vector from the node array
//   s1_vec        hare state vector from the node array
//   reset_nos     broadcast node load strobe (LOAD cycle)
//   start_s0      broadcast tortoise advance enable
//   start_s1      broadcast hare advance enable
//   init_state    registered copy of init_vec fed to every node
//   busy          high from start acceptance through the DONE cycle
//   done          one-cycle pulse when results are valid
//   timeout       step limit reached in RUN or PERIOD
//   meet_steps    hare steps applied at the Floyd meet
//   period        attractor length (0 on timeout)
module gnr_attractor_ctrl #(
    parameter int N_NODES   = 8,
    parameter int CNT_W     = 16,
    parameter int MAX_STEPS = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_NODES-1:0] init_vec,
    input  logic [N_NODES-1:0] s0_vec,
    input  logic [N_NODES-1:0] s1_vec,
    output logic               reset_nos,
    output logic               start_s0,
    output logic               start_s1,
    output logic [N_NODES-1:0] init_state,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic [CNT_W-1:0]   meet_steps,
    output logic [CNT_W-1:0]   period
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_PERIOD,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_STEPS);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   k_q, k_d;
    logic [CNT_W-1:0]   p_q, p_d;
    logic [N_NODES-1:0] init_state_q, init_state_d;
    logic               busy_q, busy_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   meet_steps_q, meet_steps_d;
    logic [CNT_W-1:0]   period_q, period_d;

    logic vec_eq;
    logic meet;
    logic back;

    assign vec_eq = (s0_vec == s1_vec);
    // Compare only on even hare counts, so the hare has taken exactly twice the
    // tortoise's steps. k=0 is excluded because both start at init.
    assign meet   = (k_q >= CNT_TWO) && !k_q[0] && vec_eq;
    // p=0 is excluded because the hare still sits on the meeting point.
    assign back   = (p_q >= CNT_ONE) && vec_eq;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            k_q          <= '0;
            p_q          <= '0;
            init_state_q <= '0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
            meet_steps_q <= '0;
            period_q     <= '0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            p_q          <= p_d;
            init_state_q <= init_state_d;
            busy_q       <= busy_d;
            timeout_q    <= timeout_d;
            meet_steps_q <= meet_steps_d;
            period_q     <= period_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        p_d          = p_q;
        init_state_d = init_state_q;
        busy_d       = busy_q;
        timeout_d    = timeout_q;
        meet_steps_d = meet_steps_q;
        period_d     = period_q;
        reset_nos    = 1'b0;
        start_s0     = 1'b0;
        start_s1     = 1'b0;
        done         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    init_state_d = init_vec;
                    timeout_d    = 1'b0;
                    meet_steps_d = '0;
                    period_d     = '0;
                    busy_d       = 1'b1;
                    state_d      = S_LOAD;
                end
            end
            S_LOAD: begin
                reset_nos = 1'b1;
                k_d       = '0;
                state_d   = S_RUN;
            end
            S_RUN: begin
                if (meet) begin
                    meet_steps_d = k_q;
                    p_d          = '0;
                    state_d      = S_PERIOD;
                end else if (k_q == CNT_MAX) begin
                    timeout_d = 1'b1;
                    period_d  = '0;
                    state_d   = S_DONE;
                end else begin
                    start_s0 = 1'b1;
                    start_s1 = 1'b1;
                    k_d      = k_q + CNT_ONE;
                end
            end
            S_PERIOD: begin
                // The tortoise is held so that it marks a fixed point on the cycle.
                if (back) begin
                    period_d = p_q;
                    state_d  = S_DONE;
                end else if (p_q == CNT_MAX) begin
                    timeout_d = 1'b1;
                    period_d  = '0;
                    state_d   = S_DONE;
                end else begin
                    start_s1 = 1'b1;
                    p_d      = p_q + CNT_ONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign init_state = init_state_q;
    assign busy       = busy_q;
    assign timeout    = timeout_q;
    assign meet_steps = meet_steps_q;
    assign period     = period_q;

endmodule
